// File: rtl/fft_iter_sequencer.sv
// fft_iter_sequencer
//   Run-level control for the iterative radix-2 FFT core. It walks LAYERS x
//   BUTTERFLYES butterflies. Before each work-RAM write-back it waits RD_LAT
//   cycles for the RAM read data. It also arbitrates input-RAM ownership
//   between the host and the engine.
//
// Ports
//   CLK         clock, rising edge
//   RST         synchronous active-high reset
//   EN          clock enable; low freezes state and masks the strobes
//   START       run request, honoured in IDLE only
//   i_HOST_REQ  host asks for input-RAM write access
//   o_HOST_GNT  host owns the input RAM (engine idle)
//   BUSY        run in progress
//   DONE        one-cycle pulse after the final write-back
//   LAY_EN      advance the address generators to the next layer
//   ADDR_EN     advance the butterfly/twiddle address generators
//   Wr          work-RAM write strobe
//   FIRST       layer 0 in progress (butterfly reads the input RAM)
//   o_LAYER     current layer index
//   o_BUTT      current butterfly index within the layer
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | engine idle, host may own input RAM, waiting for START
// S_RD   | addresses issued, waiting RD_LAT cycles for read data
// S_WR   | write-back of one butterfly, advance counters
// S_FIN  | run complete, DONE pulse, counters cleared on exit

module fft_iter_sequencer #(
  parameter int LAYERS      = 5,
  parameter int BUTTERFLYES = 16,
  parameter int LayWL       = 3,
  parameter int ButtWL      = 4,
  parameter int RD_LAT      = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              START,
  input  logic              i_HOST_REQ,
  output logic              o_HOST_GNT,
  output logic              BUSY,
  output logic              DONE,
  output logic              LAY_EN,
  output logic              ADDR_EN,
  output logic              Wr,
  output logic              FIRST,
  output logic [LayWL-1:0]  o_LAYER,
  output logic [ButtWL-1:0] o_BUTT
);

  localparam int RdWL = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [RdWL-1:0]   RD_LAST   = RdWL'(RD_LAT - 1);
  localparam logic [LayWL-1:0]  LAY_LAST  = LayWL'(LAYERS - 1);
  localparam logic [ButtWL-1:0] BUTT_LAST = ButtWL'(BUTTERFLYES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_e;

  state_e            state_q, state_d;
  logic [LayWL-1:0]  layer_q, layer_d;
  logic [ButtWL-1:0] butt_q, butt_d;
  logic [RdWL-1:0]   rd_cnt_q, rd_cnt_d;
  logic              start_pend_q, start_pend_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      layer_q      <= '0;
      butt_q       <= '0;
      rd_cnt_q     <= '0;
      start_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      butt_q       <= butt_d;
      rd_cnt_q     <= rd_cnt_d;
      start_pend_q <= start_pend_d;
    end
  end

  // Every state transition is qualified by EN, so a low EN holds the whole
  // state. The strobes are ANDed with EN so that a frozen WR or FIN cycle
  // fires exactly once, after EN returns.
  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    butt_d       = butt_q;
    rd_cnt_d     = rd_cnt_q;
    start_pend_d = start_pend_q;
    o_HOST_GNT   = 1'b0;
    BUSY         = 1'b0;
    DONE         = 1'b0;
    LAY_EN       = 1'b0;
    ADDR_EN      = 1'b0;
    Wr           = 1'b0;

    case (state_q)
      S_IDLE: begin
        o_HOST_GNT = i_HOST_REQ;
        if (EN) begin
          if (i_HOST_REQ) begin
            // Host holds the input RAM: remember the request, launch on release.
            if (START) start_pend_d = 1'b1;
          end else if (START || start_pend_q) begin
            state_d      = S_RD;
            start_pend_d = 1'b0;
            layer_d      = '0;
            butt_d       = '0;
            rd_cnt_d     = '0;
          end
        end
      end

      S_RD: begin
        BUSY = 1'b1;
        if (EN) begin
          if (rd_cnt_q == RD_LAST) begin
            state_d  = S_WR;
            rd_cnt_d = '0;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end

      S_WR: begin
        BUSY    = 1'b1;
        Wr      = EN;
        ADDR_EN = EN;
        if (butt_q == BUTT_LAST) begin
          LAY_EN = EN;
          if (EN) begin
            butt_d = '0;
            if (layer_q == LAY_LAST) begin
              state_d = S_FIN;
            end else begin
              layer_d = layer_q + 1'b1;
              state_d = S_RD;
            end
          end
        end else if (EN) begin
          butt_d  = butt_q + 1'b1;
          state_d = S_RD;
        end
      end

      S_FIN: begin
        DONE = EN;
        if (EN) begin
          state_d = S_IDLE;
          layer_d = '0;
          butt_d  = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign FIRST   = BUSY && (layer_q == '0);
  assign o_LAYER = layer_q;
  assign o_BUTT  = butt_q;

endmodule
